// File: rtl/rs_age_issue_pkg.sv
// Shared configuration for the reservation station and its age-select helper.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package rs_age_issue_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int RS_ROB_W  = 4;
  localparam int RS_TYPE_W = 5;
  localparam int RS_XLEN   = 32;
  localparam int RS_NUM_WB = 2;

  // Op-type encodings carried through the station untouched.
  typedef enum logic [RS_TYPE_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_LD  = 5'd8,
    OP_ST  = 5'd9,
    OP_BR  = 5'd16
  } rs_op_e;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int rs_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest requesting entry using an age matrix (older[i*N+j]=1: i allocated before j).
// Latency: purely combinational.
// Backpressure: none; caller decides whether to hold or consume the grant.
module rs_oldest_select
  import rs_age_issue_pkg::*;
#(
  parameter int N = RS_DEPTH
) (
  input  logic [N-1:0]         req,
  input  logic [N*N-1:0]       older,
  output logic [N-1:0]         gnt_oh,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [N-1:0] beaten;

  // An entry wins when no other requester is older than it.
  always_comb begin
    beaten  = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && older[j*N+i]) beaten[i] = 1'b1;
      end
      gnt_oh[i] = req[i] && !beaten[i];
    end
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_age_issue.sv
// Reservation station: holds ops until operands arrive, dispatches the oldest ready op to one EXU.
// Latency: insert->eligible 1 cycle (0 extra for bypassed operands); wakeup->eligible 1 cycle.
// Backpressure: exu_valid && !exu_ready locks the grant; inst_valid is dropped while full.
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int ROB_W  = RS_ROB_W,
  parameter int TYPE_W = RS_TYPE_W,
  parameter int XLEN   = RS_XLEN,
  parameter int NUM_WB = RS_NUM_WB
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_clear,
  input  logic                      inst_valid,
  input  logic [TYPE_W-1:0]         inst_type,
  input  logic [ROB_W-1:0]          inst_rob_idx,
  input  logic [XLEN-1:0]           inst_r1,
  input  logic [XLEN-1:0]           inst_r2,
  input  logic [ROB_W-1:0]          inst_dep1,
  input  logic [ROB_W-1:0]          inst_dep2,
  input  logic                      inst_has_dep1,
  input  logic                      inst_has_dep2,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      exu_valid,
  input  logic                      exu_ready,
  output logic [TYPE_W-1:0]         exu_op,
  output logic [XLEN-1:0]           exu_r1,
  output logic [XLEN-1:0]           exu_r2,
  output logic [ROB_W-1:0]          exu_rob_idx,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]   wb_idx,
  input  logic [NUM_WB*XLEN-1:0]    wb_value
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = rs_cnt_w(DEPTH);

  // Returns {hit, value}; scanning from the top channel down lets channel 0 win ties.
  function automatic logic [XLEN:0] wb_lookup(
    input logic [ROB_W-1:0]        tag,
    input logic [NUM_WB-1:0]       v,
    input logic [NUM_WB*ROB_W-1:0] idx,
    input logic [NUM_WB*XLEN-1:0]  val
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (v[k] && idx[k*ROB_W +: ROB_W] == tag) res = {1'b1, val[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  logic [DEPTH-1:0]       busy_q, hd1_q, hd2_q;
  logic [TYPE_W-1:0]      op_q   [DEPTH];
  logic [ROB_W-1:0]       rob_q  [DEPTH];
  logic [ROB_W-1:0]       dep1_q [DEPTH];
  logic [ROB_W-1:0]       dep2_q [DEPTH];
  logic [XLEN-1:0]        r1_q   [DEPTH];
  logic [XLEN-1:0]        r2_q   [DEPTH];
  logic [DEPTH*DEPTH-1:0] older_q;
  logic                   locked_q;
  logic [IDX_W-1:0]       lock_idx_q;
  logic [CNT_W-1:0]       count_q;
  logic                   full_q;

  logic [XLEN:0]          lk1 [DEPTH];
  logic [XLEN:0]          lk2 [DEPTH];
  logic [XLEN:0]          ins_lk1, ins_lk2;
  logic [DEPTH-1:0]       ready_vec, sel_oh;
  logic [IDX_W-1:0]       sel_idx, grant_idx, free_idx;
  logic                   ins, fire;
  logic [CNT_W-1:0]       count_nxt;

  // Writeback tag match for every stored operand and for the incoming op (bypass).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lk1[i] = wb_lookup(dep1_q[i], wb_valid, wb_idx, wb_value);
      lk2[i] = wb_lookup(dep2_q[i], wb_valid, wb_idx, wb_value);
    end
    ins_lk1 = wb_lookup(inst_dep1, wb_valid, wb_idx, wb_value);
    ins_lk2 = wb_lookup(inst_dep2, wb_valid, wb_idx, wb_value);
  end

  // Lowest-index free slot; the free vector is registered, so a slot freed by fire waits a cycle.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign ready_vec = busy_q & ~hd1_q & ~hd2_q;

  rs_oldest_select #(.N(DEPTH)) u_sel (
    .req     (ready_vec),
    .older   (older_q),
    .gnt_oh  (sel_oh),
    .gnt_idx (sel_idx)
  );

  assign grant_idx   = locked_q ? lock_idx_q : sel_idx;
  assign exu_valid   = (locked_q || (|sel_oh)) && rdy_in && !rob_clear && !rst_in;
  assign fire        = exu_valid && exu_ready;
  assign ins         = inst_valid && !full_q && rdy_in && !rob_clear;
  assign count_nxt   = count_q + CNT_W'(ins) - CNT_W'(fire);
  assign exu_op      = op_q[grant_idx];
  assign exu_r1      = r1_q[grant_idx];
  assign exu_r2      = r2_q[grant_idx];
  assign exu_rob_idx = rob_q[grant_idx];
  assign count       = count_q;
  assign full        = full_q;

  // Entry state, age matrix, grant lock and occupancy; flush behaves exactly like reset.
  always_ff @(posedge clk_in) begin
    if (rst_in || rob_clear) begin
      busy_q     <= '0;
      older_q    <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && hd1_q[i] && lk1[i][XLEN]) begin
          r1_q[i]  <= lk1[i][XLEN-1:0];
          hd1_q[i] <= 1'b0;
        end
        if (busy_q[i] && hd2_q[i] && lk2[i][XLEN]) begin
          r2_q[i]  <= lk2[i][XLEN-1:0];
          hd2_q[i] <= 1'b0;
        end
      end
      if (fire) begin
        busy_q[grant_idx] <= 1'b0;
        locked_q          <= 1'b0;
      end else if (exu_valid) begin
        locked_q   <= 1'b1;
        lock_idx_q <= grant_idx;
      end
      if (ins) begin
        busy_q[free_idx] <= 1'b1;
        op_q[free_idx]   <= inst_type;
        rob_q[free_idx]  <= inst_rob_idx;
        dep1_q[free_idx] <= inst_dep1;
        dep2_q[free_idx] <= inst_dep2;
        r1_q[free_idx]   <= (inst_has_dep1 && ins_lk1[XLEN]) ? ins_lk1[XLEN-1:0] : inst_r1;
        r2_q[free_idx]   <= (inst_has_dep2 && ins_lk2[XLEN]) ? ins_lk2[XLEN-1:0] : inst_r2;
        hd1_q[free_idx]  <= inst_has_dep1 && !ins_lk1[XLEN];
        hd2_q[free_idx]  <= inst_has_dep2 && !ins_lk2[XLEN];
        for (int j = 0; j < DEPTH; j++) begin
          older_q[int'(free_idx)*DEPTH + j] <= 1'b0;
          older_q[j*DEPTH + int'(free_idx)] <= (j != int'(free_idx));
        end
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// Directed bench for rs_age_issue: vector table plus hand-written multi-cycle sequences.
// Latency: inputs driven on negedge, outputs sampled 1ns later.
// Backpressure: exu_ready driven per vector.
module tb_rs_age_issue;
  import rs_age_issue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, inst_valid;
  logic [4:0]  inst_type;
  logic [3:0]  inst_rob_idx, inst_dep1, inst_dep2;
  logic [31:0] inst_r1, inst_r2;
  logic        inst_has_dep1, inst_has_dep2;
  logic        full;
  logic [3:0]  count;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_op;
  logic [31:0] exu_r1, exu_r2;
  logic [3:0]  exu_rob_idx;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_idx;
  logic [63:0] wb_value;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  rs_age_issue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_idx(inst_rob_idx),
    .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
    .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
    .full(full), .count(count), .exu_valid(exu_valid), .exu_ready(exu_ready),
    .exu_op(exu_op), .exu_r1(exu_r1), .exu_r2(exu_r2), .exu_rob_idx(exu_rob_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value)
  );

  typedef struct {
    logic        rst, clr, iv;
    logic [3:0]  rob;
    logic [31:0] r1;
    logic [3:0]  dep1;
    logic        hd1, exr;
    logic [1:0]  wbv;
    logic [3:0]  wt0, wt1;
    logic [31:0] wv0, wv1;
    logic        ev;
    logic [3:0]  erob;
    logic [31:0] er1;
    logic [3:0]  ecnt;
    logic        efull;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst, input logic clr, input logic iv, input logic [3:0] rob,
    input logic [31:0] r1, input logic [3:0] dep1, input logic hd1, input logic exr,
    input logic [1:0] wbv, input logic [3:0] wt0, input logic [31:0] wv0,
    input logic [3:0] wt1, input logic [31:0] wv1,
    input logic ev, input logic [3:0] erob, input logic [31:0] er1,
    input logic [3:0] ecnt, input logic efull);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.rob = rob; v.r1 = r1; v.dep1 = dep1;
    v.hd1 = hd1; v.exr = exr; v.wbv = wbv; v.wt0 = wt0; v.wv0 = wv0; v.wt1 = wt1;
    v.wv1 = wv1; v.ev = ev; v.erob = erob; v.er1 = er1; v.ecnt = ecnt; v.efull = efull;
    return v;
  endfunction

  task automatic idle();
    rst_in = 1'b0; rob_clear = 1'b0; rdy_in = 1'b1; inst_valid = 1'b0;
    inst_type = '0; inst_rob_idx = '0; inst_r1 = '0; inst_r2 = '0;
    inst_dep1 = '0; inst_dep2 = '0; inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0;
    exu_ready = 1'b0; wb_valid = '0; wb_idx = '0; wb_value = '0;
  endtask

  // Op payload convention: type = {0,tag}, r2 = 0x2000 + tag, so payload checks follow from the tag.
  task automatic ins(input logic [3:0] rob, input logic [31:0] r1, input logic [3:0] dep1, input logic hd1);
    inst_valid = 1'b1; inst_rob_idx = rob; inst_type = {1'b0, rob};
    inst_r1 = r1; inst_r2 = 32'h2000 + 32'(rob); inst_dep1 = dep1; inst_has_dep1 = hd1;
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, nm, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [3:0] erob,
                            input logic [31:0] er1, input logic [3:0] ecnt, input logic efull);
    n_vec++;
    chk(tag, "exu_valid", 32'(exu_valid), 32'(ev));
    chk(tag, "count", 32'(count), 32'(ecnt));
    chk(tag, "full", 32'(full), 32'(efull));
    if (ev) begin
      chk(tag, "exu_rob_idx", 32'(exu_rob_idx), 32'(erob));
      chk(tag, "exu_r1", exu_r1, er1);
      chk(tag, "exu_r2", exu_r2, 32'h2000 + 32'(erob));
      chk(tag, "exu_op", 32'(exu_op), 32'(erob));
    end
  endtask

  task automatic cyc(input string tag, input logic ev, input logic [3:0] erob,
                     input logic [31:0] er1, input logic [3:0] ecnt, input logic efull);
    #1;
    expect_out(tag, ev, erob, er1, ecnt, efull);
    @(negedge clk_in);
  endtask

  initial begin
    //            rst clr iv rob r1          dep hd exr wbv wt0 wv0       wt1 wv1         ev rob er1         cnt full
    tv.push_back(mk(1, 0, 0, 0,  0,          0,  0, 0,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    // three ready ops, stalled then drained oldest-first
    tv.push_back(mk(0, 0, 1, 1,  32'h101,    0,  0, 0,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    tv.push_back(mk(0, 0, 1, 2,  32'h102,    0,  0, 0,  0,  0,  0,        0,  0,          1, 1,  32'h101,    1,  0));
    tv.push_back(mk(0, 0, 1, 3,  32'h103,    0,  0, 0,  0,  0,  0,        0,  0,          1, 1,  32'h101,    2,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 1,  32'h101,    3,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 2,  32'h102,    2,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 3,  32'h103,    1,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    // tag 5 waits on 9, tag 6 ready; wakeup on channel 1 (channel 0 carries an unrelated tag)
    tv.push_back(mk(0, 0, 1, 5,  0,          9,  1, 1,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    tv.push_back(mk(0, 0, 1, 6,  32'h606,    0,  0, 1,  0,  0,  0,        0,  0,          0, 0,  0,          1,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  3,  3,  32'h333,  9,  32'hDEAD,   1, 6,  32'h606,    2,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 5,  32'hDEAD,   1,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    // bypass on insert: dep 4 produced on channel 0 in the same cycle
    tv.push_back(mk(0, 0, 1, 8,  0,          4,  1, 1,  1,  4,  32'h11,   0,  0,          0, 0,  0,          0,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 8,  32'h11,     1,  0));
    // both channels return tag 7: channel 0 wins
    tv.push_back(mk(0, 0, 1, 10, 0,          7,  1, 1,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  3,  7,  32'hA,    7,  32'hB,      0, 0,  0,          1,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          1, 10, 32'hA,      1,  0));
    tv.push_back(mk(0, 0, 0, 0,  0,          0,  0, 1,  0,  0,  0,        0,  0,          0, 0,  0,          0,  0));

    idle();
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int n = 0; n < tv.size(); n++) begin
      idle();
      rst_in = tv[n].rst;
      rob_clear = tv[n].clr;
      if (tv[n].iv) ins(tv[n].rob, tv[n].r1, tv[n].dep1, tv[n].hd1);
      exu_ready = tv[n].exr;
      wb_valid = tv[n].wbv;
      wb_idx = {tv[n].wt1, tv[n].wt0};
      wb_value = {tv[n].wv1, tv[n].wv0};
      cyc($sformatf("v%0d", n), tv[n].ev, tv[n].erob, tv[n].er1, tv[n].ecnt, tv[n].efull);
    end

    // Fill to DEPTH with the EXU stalled; the lock holds tag 0 throughout.
    for (int t = 0; t < 8; t++) begin
      idle(); ins(4'(t), 32'h100 + 32'(t), 0, 0);
      cyc($sformatf("fill%0d", t), t > 0, 0, 32'h100, 4'(t), 1'b0);
    end
    idle(); ins(9, 32'h109, 0, 0);
    cyc("full_drop", 1, 0, 32'h100, 8, 1);
    idle();
    cyc("full_hold", 1, 0, 32'h100, 8, 1);
    idle(); rob_clear = 1'b1; exu_ready = 1'b1;
    cyc("clear_cyc", 0, 0, 0, 8, 1);
    idle(); exu_ready = 1'b1;
    cyc("clear_after", 0, 0, 0, 0, 0);

    // Insert and fire in the same cycle keeps count unchanged.
    idle(); ins(11, 32'h111, 0, 0); exu_ready = 1'b1;
    cyc("if_a", 0, 0, 0, 0, 0);
    idle(); ins(12, 32'h112, 0, 0); exu_ready = 1'b1;
    cyc("if_b", 1, 11, 32'h111, 1, 0);
    idle(); exu_ready = 1'b1;
    cyc("if_c", 1, 12, 32'h112, 1, 0);
    idle();
    cyc("if_d", 0, 0, 0, 0, 0);

    // Held grant: tag 2 locked while the older tag 1 wakes up; rdy_in low freezes everything.
    idle(); ins(1, 0, 12, 1);
    cyc("lk_1", 0, 0, 0, 0, 0);
    idle(); ins(2, 32'h22, 0, 0);
    cyc("lk_2", 0, 0, 0, 1, 0);
    idle(); wb_valid = 2'b01; wb_idx = {4'd0, 4'd12}; wb_value = {32'h0, 32'h1212};
    cyc("lk_3", 1, 2, 32'h22, 2, 0);
    idle();
    cyc("lk_4", 1, 2, 32'h22, 2, 0);
    idle(); rdy_in = 1'b0; exu_ready = 1'b1; ins(15, 32'h115, 0, 0);
    cyc("lk_frozen", 0, 0, 0, 2, 0);
    idle(); exu_ready = 1'b1;
    cyc("lk_fire2", 1, 2, 32'h22, 2, 0);
    idle(); exu_ready = 1'b1;
    cyc("lk_fire1", 1, 1, 32'h1212, 1, 0);
    idle(); exu_ready = 1'b1;
    cyc("lk_empty", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
